mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares one single-port instruction/data memory bus between the fetch stage (pc_reg/if_id side) and the memory-access stage (mem side) of the 5-stage pipeline. It grants the bus to one requester per transaction and sequences each transaction through a registered state machine. Data requests take priority and fetch requests are guaranteed service. It raises per-port stall requests toward the pipeline stall controller, and it discards fetches cancelled by a pipeline flush.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports; SEL_W = DATA_W/8
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state immediately
- if_req_i  in  1  fetch request; held high until if_ack_o
- if_addr_i  in  ADDR_W  fetch address (pc); stable while if_req_i high, except after flush_i
- if_inst_o  out  DATA_W  fetched instruction; valid only when if_ack_o=1, else 0
- if_ack_o  out  1  fetch complete, single-cycle pulse
- mem_req_i  in  1  data request; held high until mem_ack_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_sel_i  in  SEL_W  byte enables
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  write data
- mem_rdata_o  out  DATA_W  read data; valid only when mem_ack_o=1, else 0
- mem_ack_o  out  1  data complete, single-cycle pulse
- flush_i  in  1  pipeline flush pulse; cancels the current/pending fetch
- bus_req_o  out  1  bus cycle active (registered)
- bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o  out  1/SEL_W/ADDR_W/DATA_W  registered copies of the granted request
- bus_rdata_i  in  DATA_W  slave read data, valid with bus_ack_i
- bus_ack_i  in  1  slave completion; ignored when bus_req_o=0
- grant_o  out  2  01 = fetch owns bus, 10 = data owns bus, 00 = idle
- stallreq_if_o  out  1  if_req_i & ~if_ack_o
- stallreq_mem_o  out  1  mem_req_i & ~mem_ack_o

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM. grant_o and bus_req_o are decoded from state; bus_req_o=1 in both BUSY states.
- IDLE: mem_req_i=1 -> BUSY_MEM, latching we/sel/addr/wdata. Otherwise if_req_i=1 and no flush_i -> BUSY_IF, latching if_addr_i with we=0 and sel=all ones. Otherwise stay.
- BUSY_x with bus_ack_i=0: hold; bus outputs stay constant.
- BUSY_IF with bus_ack_i=1: if_ack_o = ~drop, if_inst_o = bus_rdata_i when acked. Next state is BUSY_MEM if mem_req_i=1, else IDLE. The fetch port is never re-granted on its own ack cycle.
- BUSY_MEM with bus_ack_i=1: mem_ack_o=1, mem_rdata_o = bus_rdata_i (on reads, 0 on writes). Next state is BUSY_IF if if_req_i=1 and no flush_i, else IDLE. Alternation guarantees fetch service after every data access.
- drop flag: set by flush_i while in BUSY_IF. It suppresses if_ack_o for that transaction and clears when the transaction completes. A flush in the ack cycle itself also suppresses the ack. flush_i does not affect BUSY_MEM. A flush in IDLE blocks the fetch grant for that cycle only.
- Acks are combinational from bus_ack_i and state/drop. Stall outputs are combinational.
- Reset values: state IDLE, drop 0, bus_req_o 0, bus_we_o 0, bus_sel_o 0, bus_addr_o 0, bus_wdata_o 0, grant_o 00, if_ack_o 0, mem_ack_o 0, if_inst_o 0, mem_rdata_o 0.
- Reset mid-transaction abandons the bus cycle: bus_req_o drops asynchronously. The slave must tolerate abandonment.

## Timing
- Request sampled in IDLE at edge t -> bus_req_o high from cycle t+1.
- Slave ack in cycle k -> requester ack in cycle k (zero added latency on the return path).
- Minimum transaction: request cycle t, ack t+1. Idle-to-ack latency is 1 + slave wait states.
- Chained transaction for the other port starts at k+1 with no idle cycle. A same-port repeat passes through IDLE and starts at k+2.
- Worst-case fetch wait with continuous data traffic is one data transaction plus its own.

## Test plan
- Lone fetch: if_req_i=1, addr 0x00000100, slave acks 2 cycles after bus_req_o with 0x3C011234 -> bus_addr_o=0x100, grant_o=01. if_ack_o pulses once with if_inst_o=0x3C011234. stallreq_if_o is high on every prior cycle.
- Simultaneous requests: fetch 0x104 and data write 0xDEADBEEF to 0x200, sel 1111, same cycle -> BUSY_MEM first with bus_we_o=1. On the mem ack the arbiter chains straight to BUSY_IF with bus_addr_o=0x104 the next cycle, with no idle gap.
- Alternation: both ports re-request continuously for 6 transactions -> grant sequence 10,01,10,01,10,01. No port is granted twice in a row.
- Flush mid-fetch: flush_i during BUSY_IF at 0x108, then the requester presents 0x200 -> no if_ack_o for 0x108. IDLE follows, then a new fetch of 0x200 acks normally.
- Flush on the ack cycle with mem_req_i pending -> if_ack_o stays 0 and the next state is BUSY_MEM.
- Async reset asserted mid-BUSY_MEM, between clock edges -> bus_req_o, grant_o and acks go to 0 immediately, before the next edge. After release, the pending requests re-arbitrate from IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the fetch and data ports of the pipeline.
// Data wins ties; the two ports alternate on back-to-back traffic, so a waiting fetch is always served next.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic [1:0]        grant_o,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t state, state_nxt;
  logic   drop, drop_nxt;
  logic   load_if, load_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  // A fetch is never re-granted on its own ack cycle; a data ack hands straight over to a waiting fetch.
  always_comb begin
    state_nxt = state;
    load_if   = 1'b0;
    load_mem  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_i) begin
          state_nxt = BUSY_MEM;
          load_mem  = 1'b1;
        end else if (if_req_i && !flush_i) begin
          state_nxt = BUSY_IF;
          load_if   = 1'b1;
        end
      end
      BUSY_IF: begin
        if (bus_ack_i) begin
          if (mem_req_i) begin
            state_nxt = BUSY_MEM;
            load_mem  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      BUSY_MEM: begin
        if (bus_ack_i) begin
          if (if_req_i && !flush_i) begin
            state_nxt = BUSY_IF;
            load_if   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A flushed fetch still runs to completion on the bus, but its ack is swallowed.
  assign drop_nxt = (state == BUSY_IF) && !bus_ack_i && (drop || flush_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else if (load_mem) begin
      bus_we_o    <= mem_we_i;
      bus_sel_o   <= mem_sel_i;
      bus_addr_o  <= mem_addr_i;
      bus_wdata_o <= mem_wdata_i;
    end else if (load_if) begin
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '1;
      bus_addr_o  <= if_addr_i;
      bus_wdata_o <= '0;
    end
  end

  assign bus_req_o = (state != IDLE);
  assign grant_o   = {state == BUSY_MEM, state == BUSY_IF};

  assign if_ack_o    = (state == BUSY_IF) && bus_ack_i && !drop && !flush_i;
  assign if_inst_o   = if_ack_o ? bus_rdata_i : '0;
  assign mem_ack_o   = (state == BUSY_MEM) && bus_ack_i;
  assign mem_rdata_o = (mem_ack_o && !bus_we_o) ? bus_rdata_i : '0;

  assign stallreq_if_o  = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

endmodule
